divu_sequencer: RTL and testbench
=================================

DIVU_SEQUENCER -- requirements
Module: divu_sequencer

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  reset; synchronous, active-high.
REQ-003 SHALL: op_valid  input  1  request to start a HI/LO operation this cycle.
REQ-004 SHALL: op_mul  input  1  0 = DIVU, 1 = MULTU; sampled with op_valid.
REQ-005 SHALL: srca  input  32  dividend / multiplicand (rs value).
REQ-006 SHALL: srcb  input  32  divisor / multiplier (rt value).
REQ-007 SHALL: rd_req  input  1  MFHI/MFLO instruction in execute this cycle.
REQ-008 SHALL: rd_sel  input  1  0 = LO (MFLO), 1 = HI (MFHI).
REQ-009 SHALL: rd_data  output  32  selected HI or LO value, combinational from registers.
REQ-010 SHALL: busy  output  1  high while an operation is in flight.
REQ-011 SHALL: stall  output  1  pipeline hold request to the datapath.
REQ-012 SHALL: done  output  1  one-cycle pulse when HI/LO receive a new result.
REQ-013 SHALL: dz  output  1  sticky flag: last DIVU had divisor 0.

Function
REQ-014 SHALL: states IDLE, RUN, DONE; reset enters IDLE.
REQ-015 SHALL: in IDLE, op_valid=1 latches srca, srcb, op_mul into internal registers, clears iteration counter to 0, and moves to RUN; the registers are not re-sampled during the operation.
REQ-016 SHALL: in RUN, perform one restoring shift-subtract step per cycle on a 33-bit partial remainder (DIVU) and a 6-bit counter; after step 31 move to DONE.
REQ-017 SHALL: on the DONE transition, write HI = remainder and LO = quotient; in DONE, pulse done for exactly one cycle, then return to IDLE.
REQ-018 SHALL: latency from accepting cycle to done = 33 cycles; accept-to-next-accept minimum = 34 cycles.
REQ-019 SHALL: DIVU with srcb = 0 skips RUN, goes IDLE->DONE, writes HI = srca, LO = 32'hFFFFFFFF, and sets dz; any DIVU with nonzero divisor clears dz at its DONE.
REQ-020 SHALL: busy = 1 in RUN and DONE, 0 in IDLE.
REQ-021 SHALL: stall = busy AND (rd_req OR op_valid); stall = 0 in IDLE regardless of inputs.
REQ-022 SHALL: op_valid while busy is not accepted and not queued; the datapath re-presents it while stall is high.
REQ-023 SHALL: rd_req with op_valid in the same IDLE cycle returns the old HI/LO and accepts the new operation.
REQ-024 SHALL: in the DONE cycle rd_data already reflects the new HI/LO (registers written on entry to DONE), but stall stays high for that cycle; read completes in the following IDLE cycle.
REQ-025 SHALL: HI/LO are modified only by a completed operation or reset.

Reset
REQ-026 SHALL: reset forces state IDLE, HI = 0, LO = 0, counter = 0, dz = 0, done = 0, busy = 0, stall = 0.
REQ-027 SHALL: reset during RUN or DONE aborts the operation with no HI/LO update and no done pulse.
REQ-028 SHALL: reset has priority over op_valid in the same cycle.

Configuration
REQ-029 SHALL: macro DIVU_SEQUENCER_MULTU_EN compiles in MULTU support.
REQ-030 SHALL: with DIVU_SEQUENCER_MULTU_EN defined, op_mul=1 runs a 32-step shift-add in RUN with the same 33-cycle latency and writes {HI,LO} = srca * srcb (64-bit unsigned); dz is unaffected.
REQ-031 SHALL: without the macro, op_valid with op_mul=1 is ignored in IDLE (no state change, no stall, HI/LO unchanged) and no multiply logic is present.

Verification
REQ-032 SHALL: DIVU srca=100, srcb=7 -> done 33 cycles after accept; LO=14, HI=2, dz=0.
REQ-033 SHALL: DIVU srca=32'hFFFFFFFF, srcb=1 -> LO=32'hFFFFFFFF, HI=0; then srca=5, srcb=0 -> done next+1 cycle, HI=5, LO=32'hFFFFFFFF, dz=1.
REQ-034 SHALL: MFLO (rd_req=1, rd_sel=0) held from cycle 2 after accept of 100/7 -> stall=1 through DONE, rd_data=14 in first IDLE cycle with stall=0.
REQ-035 SHALL: second op_valid issued mid-RUN -> stall=1, not accepted until IDLE, first result intact in HI/LO at its done.
REQ-036 SHALL: reset asserted at RUN step 10 of 100/7 after prior result HI=3, LO=9 -> HI=0, LO=0, no done pulse, busy=0 next cycle.
REQ-037 SHALL: with DIVU_SEQUENCER_MULTU_EN, MULTU 32'hFFFFFFFF x 2 -> HI=1, LO=32'hFFFFFFFE after 33 cycles; without the macro, same stimulus -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/divu_sequencer.sv
// divu_sequencer
//   Multi-cycle HI/LO unit for an in-order pipeline. It computes an unsigned
//   32-bit divide (DIVU) with a restoring shift-subtract loop, one quotient bit
//   per cycle. The results go into the architectural HI (remainder) and LO
//   (quotient) registers. While an operation is in flight it asks the pipeline
//   to hold any instruction that needs HI/LO or that issues another operation.
//
//   Timing: the operation is accepted in the IDLE cycle. After that come 32
//   RUN cycles and one DONE cycle. done is high 33 cycles after the accepting
//   cycle, and the earliest next accept comes one cycle after DONE.
//   A divide by zero skips RUN and goes straight to DONE.
//
//   Optional feature (compile-time macro DIVU_SEQUENCER_MULTU_EN):
//     Adds MULTU, a 32-step shift-add multiply with the same latency.
//     It writes {HI,LO} = srca * srcb. Without the macro, a request with
//     op_mul=1 is ignored.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   op_valid  in   start request (IDLE only; ignored while busy)
//   op_mul    in   0 = DIVU, 1 = MULTU (sampled with op_valid)
//   srca      in   32  dividend / multiplicand
//   srcb      in   32  divisor / multiplier
//   rd_req    in   MFHI/MFLO in execute
//   rd_sel    in   0 = LO, 1 = HI
//   rd_data   out  32  selected HI/LO, combinational from the registers
//   busy      out  high in RUN and DONE
//   stall     out  busy & (rd_req | op_valid)
//   done      out  one-cycle pulse in the cycle after HI/LO take a result
//   dz        out  sticky: last DIVU had a zero divisor
module divu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_mul,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] hi, lo;
  logic        dz_r;

  // Working registers. They are written only on accept and during RUN, and
  // they are never re-sampled from the ports mid-operation.
  //   rem : partial remainder (DIVU) or upper product accumulator (MULTU)
  //   quo : dividend shifting into quotient, or multiplier shifting into
  //         the low product word
  //   dvs : divisor or multiplicand
  logic [31:0] rem, quo, dvs;
  logic [31:0] rem_nxt, quo_nxt;

  logic        accept;
  logic        zero_div;
  logic        last_step;

  // One restoring division step. The 33-bit trial value {rem, next dividend
  // bit} is compared against the divisor by subtracting. A borrow out of
  // bit 32 means "does not fit", and then the shifted value is kept.
  function automatic logic [63:0] div_step(input logic [31:0] r,
                                           input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] r_sh;
    logic [32:0] diff;
    r_sh = {r, q[31]};
    diff = r_sh - {1'b0, d};
    if (!diff[32])
      div_step = {diff[31:0], q[30:0], 1'b1};
    else
      div_step = {r_sh[31:0], q[30:0], 1'b0};
  endfunction

`ifdef DIVU_SEQUENCER_MULTU_EN
  logic mul_r;

  // One shift-add multiply step. The multiplicand is added when the
  // multiplier LSB is set, and then the 65-bit {carry, acc, mq} shifts right.
  // After 32 steps acc holds the high word and mq holds the low word.
  function automatic logic [63:0] mul_step(input logic [31:0] acc,
                                           input logic [31:0] mq,
                                           input logic [31:0] d);
    logic [32:0] sum;
    sum = {1'b0, acc} + (mq[0] ? {1'b0, d} : 33'd0);
    mul_step = {sum[32:1], sum[0], mq[31:1]};
  endfunction

  assign accept = (state == IDLE) && op_valid;
  assign zero_div = accept && !op_mul && (srcb == 32'd0);

  always_comb begin
    if (mul_r)
      {rem_nxt, quo_nxt} = mul_step(rem, quo, dvs);
    else
      {rem_nxt, quo_nxt} = div_step(rem, quo, dvs);
  end
`else
  // Without multiply support, a multiply request does not count as a request.
  assign accept = (state == IDLE) && op_valid && !op_mul;
  assign zero_div = accept && (srcb == 32'd0);

  always_comb begin
    {rem_nxt, quo_nxt} = div_step(rem, quo, dvs);
  end
`endif

  assign last_step = (state == RUN) && (cnt == 6'd31);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = zero_div ? DONE : RUN;
      end
      RUN: begin
        if (cnt == 6'd31)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, step counter, and the architectural HI/LO/dz registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 6'd0;
      else if (state == RUN)
        cnt <= cnt + 6'd1;

      if (zero_div) begin
        hi   <= srca;
        lo   <= 32'hFFFF_FFFF;
        dz_r <= 1'b1;
      end else if (last_step) begin
        // The final step's results go straight into HI/LO, so the new value
        // is already visible in the DONE cycle.
        hi <= rem_nxt;
        lo <= quo_nxt;
`ifdef DIVU_SEQUENCER_MULTU_EN
        if (!mul_r)
          dz_r <= 1'b0;
`else
        dz_r <= 1'b0;
`endif
      end
    end
  end

  // Datapath: operand latch on accept, one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      rem <= 32'd0;
      quo <= srca;
      dvs <= srcb;
`ifdef DIVU_SEQUENCER_MULTU_EN
      mul_r <= op_mul;
`endif
    end else if (state == RUN) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  // The status outputs are also forced low by reset in the same cycle. This
  // way a reset during DONE cannot show a done pulse for an aborted operation.
  assign busy    = (state != IDLE) && !reset;
  assign done    = (state == DONE) && !reset;
  assign stall   = busy && (rd_req || op_valid);
  assign rd_data = rd_sel ? hi : lo;
  assign dz      = dz_r;

endmodule

// File: tb/tb_divu_sequencer.sv
module tb_divu_sequencer;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_mul, rd_req, rd_sel;
  logic [31:0] srca, srcb, rd_data;
  logic        busy, stall, done, dz;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  logic model_dz;
  logic [31:0] last_hi, last_lo;

  divu_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_mul(op_mul),
    .srca(srca), .srcb(srcb), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo,
                              input logic d, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = d; e.lat = lat;
    return e;
  endfunction

  // Ticks until done is high or the cycle bound runs out. n counts cycles
  // since the accepting edge.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    logic save;
    save = rd_sel;
    rd_sel = 1'b0; #1;
    check({tag, "_lo"}, {32'd0, rd_data}, {32'd0, lo});
    rd_sel = 1'b1; #1;
    check({tag, "_hi"}, {32'd0, rd_data}, {32'd0, hi});
    rd_sel = save; #1;
  endtask

  // Issues one operation, pushes its expected result, and then pops and
  // compares it when done pulses.
  task automatic do_op(input string tag, input logic mul, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    int n;
    exp_t got_e;
    srca = a; srcb = b; op_mul = mul; op_valid = 1'b1;
    sb.push_back(e);
    tick();
    op_valid = 1'b0; op_mul = 1'b0;
    wait_done(1, n);
    got_e = sb.pop_front();
    check({tag, "_latency"}, 64'(n), 64'(got_e.lat));
    check_hilo(tag, got_e.hi, got_e.lo);
    check({tag, "_dz"}, {63'd0, dz}, {63'd0, got_e.dz});
    tick();
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_idle_done"}, {63'd0, done}, 64'd0);
    last_hi = got_e.hi; last_lo = got_e.lo; model_dz = got_e.dz;
  endtask

  initial begin
    int n;
    int stall_low;
    logic [31:0] ra, rb;
    logic [63:0] p;

    tbl[0] = '{a: 32'd100,        b: 32'd7,          hi: 32'd2,        lo: 32'd14,         dz: 1'b0};
    tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          hi: 32'd0,        lo: 32'hFFFF_FFFF,  dz: 1'b0};
    tbl[2] = '{a: 32'd5,          b: 32'd0,          hi: 32'd5,        lo: 32'hFFFF_FFFF,  dz: 1'b1};
    tbl[3] = '{a: 32'd1000,       b: 32'd10,         hi: 32'd0,        lo: 32'd100,        dz: 1'b0};
    tbl[4] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'd0,        lo: 32'd1,          dz: 1'b0};
    tbl[5] = '{a: 32'd7,          b: 32'd100,        hi: 32'd7,        lo: 32'd0,          dz: 1'b0};
    tbl[6] = '{a: 32'd0,          b: 32'd0,          hi: 32'd0,        lo: 32'hFFFF_FFFF,  dz: 1'b1};
    tbl[7] = '{a: 32'h8000_0000,  b: 32'd3,          hi: 32'd2,        lo: 32'h2AAA_AAAA,  dz: 1'b0};
    tbl[8] = '{a: 32'd39,         b: 32'd4,          hi: 32'd3,        lo: 32'd9,          dz: 1'b0};

    // Reset, with a competing request asserted to show that reset wins.
    reset = 1'b1; op_valid = 1'b1; op_mul = 1'b0; srca = 32'd1; srcb = 32'd1;
    rd_req = 1'b1; rd_sel = 1'b0;
    tick(); tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    op_valid = 1'b0; reset = 1'b0; rd_req = 1'b0;
    tick();
    check("rst_dz", {63'd0, dz}, 64'd0);
    check("rst_busy_after", {63'd0, busy}, 64'd0);
    check_hilo("rst", 32'd0, 32'd0);

    // An idle read does not stall.
    rd_req = 1'b1; #1;
    check("idle_rd_stall", {63'd0, stall}, 64'd0);
    rd_req = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), 1'b0, tbl[i].a, tbl[i].b,
            mk(tbl[i].hi, tbl[i].lo, tbl[i].dz, (tbl[i].b == 32'd0) ? 1 : 33));

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      do_op($sformatf("rnd%0d", i), 1'b0, ra, rb, mk(ra % rb, ra / rb, 1'b0, 33));
    end

    // MFLO held from the second cycle after accept: it stalls through DONE,
    // and the read completes in the first IDLE cycle.
    srca = 32'd100; srcb = 32'd7; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    rd_req = 1'b1; rd_sel = 1'b0; #1;
    stall_low = 0;
    n = 2;
    while (!done && n < 40) begin
      if (!stall) stall_low++;
      tick();
      n++;
    end
    check("rd_done_seen", {63'd0, done}, 64'd1);
    check("rd_stall_run", 64'(stall_low), 64'd0);
    check("rd_stall_done", {63'd0, stall}, 64'd1);
    check("rd_data_done", {32'd0, rd_data}, 64'd14);
    tick();
    check("rd_stall_idle", {63'd0, stall}, 64'd0);
    check("rd_data_idle", {32'd0, rd_data}, 64'd14);
    rd_req = 1'b0;

    // A second request mid-RUN stalls and is not taken until IDLE. The first
    // result stays intact, even though the operand ports have changed.
    srca = 32'd100; srcb = 32'd7; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    srca = 32'd50; srcb = 32'd3; op_valid = 1'b1; #1;
    check("q_stall", {63'd0, stall}, 64'd1);
    wait_done(11, n);
    check("q_first_lat", 64'(n), 64'd33);
    check_hilo("q_first", 32'd2, 32'd14);
    tick();
    rd_req = 1'b1; rd_sel = 1'b0; #1;
    check("q_idle_busy", {63'd0, busy}, 64'd0);
    check("q_idle_stall", {63'd0, stall}, 64'd0);
    check("q_idle_old_lo", {32'd0, rd_data}, 64'd14);
    sb.push_back(mk(32'd2, 32'd16, 1'b0, 33));
    tick();
    rd_req = 1'b0; op_valid = 1'b0;
    check("q_second_busy", {63'd0, busy}, 64'd1);
    wait_done(1, n);
    begin
      exp_t e;
      e = sb.pop_front();
      check("q_second_lat", 64'(n), 64'(e.lat));
      check_hilo("q_second", e.hi, e.lo);
      last_hi = e.hi; last_lo = e.lo;
    end
    tick();

`ifdef DIVU_SEQUENCER_MULTU_EN
    do_op("mul_max", 1'b1, 32'hFFFF_FFFF, 32'd2, mk(32'd1, 32'hFFFF_FFFE, model_dz, 33));
    ra = $urandom; rb = $urandom;
    p = {32'd0, ra} * {32'd0, rb};
    do_op("mul_rnd", 1'b1, ra, rb, mk(p[63:32], p[31:0], model_dz, 33));
`else
    op_valid = 1'b1; op_mul = 1'b1; srca = 32'hFFFF_FFFF; srcb = 32'd2; #1;
    check("nomul_stall", {63'd0, stall}, 64'd0);
    tick();
    check("nomul_busy", {63'd0, busy}, 64'd0);
    tick(); tick();
    check("nomul_busy2", {63'd0, busy}, 64'd0);
    check("nomul_done", {63'd0, done}, 64'd0);
    op_valid = 1'b0; op_mul = 1'b0;
    check_hilo("nomul", last_hi, last_lo);
    p = 64'd0;
`endif

    // Reset during RUN aborts the operation: HI/LO are cleared and no done
    // pulse follows.
    do_op("pre_rst", 1'b0, 32'd39, 32'd4, mk(32'd3, 32'd9, 1'b0, 33));
    srca = 32'd100; srcb = 32'd7; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check_hilo("abort", 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) n++;
      tick();
    end
    check("abort_no_done", 64'(n), 64'd0);
    check("abort_dz", {63'd0, dz}, 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
